// File: rtl/display_sequencer_if.sv
// Display sequencer bus.
// The vending side drives the snapshot/strobe signals.
// The overlay side consumes the tear-free display values.
interface display_sequencer_if;
    logic       frame_start;
    logic       upd_valid;
    logic [1:0] upd_state;
    logic [7:0] upd_total;
    logic [7:0] upd_change;
    logic [1:0] upd_item;
    logic       dispense;

    logic [1:0] disp_state;
    logic [7:0] disp_total;
    logic [7:0] disp_change;
    logic [1:0] disp_item;
    logic       show_text;
    logic       banner_active;

    modport master (
        output frame_start, upd_valid, upd_state, upd_total, upd_change, upd_item, dispense,
        input  disp_state, disp_total, disp_change, disp_item, show_text, banner_active
    );

    modport slave (
        input  frame_start, upd_valid, upd_state, upd_total, upd_change, upd_item, dispense,
        output disp_state, disp_total, disp_change, disp_item, show_text, banner_active
    );
endinterface

// File: rtl/display_sequencer.sv
// Display sequencer: double-buffers vending-FSM snapshots so the overlay
// only changes at vertical blanking, shows a timed "dispensed" banner,
// and blinks the idle attract text.
module display_sequencer #(
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                clk_25mhz,
    input  logic                reset_n,
    display_sequencer_if.slave  bus
);

    typedef enum logic {
        S_LIVE   = 1'b0,
        S_BANNER = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_hold_cnt, w_hold_nxt;
    logic       w_load_banner;

    logic       r_pending;
    logic [1:0] r_shadow_state;
    logic [7:0] r_shadow_total;
    logic [7:0] r_shadow_change;
    logic [1:0] r_shadow_item;

    logic [1:0] r_live_state;
    logic [1:0] r_live_item;
    logic [7:0] r_disp_total;
    logic [7:0] r_disp_change;

    logic       r_dispense_pend;
    logic [1:0] r_banner_item;
    logic [1:0] r_banner_shown;

    logic [7:0] r_blink_cnt;
    logic       r_blink_show;

    logic       w_apply_now;
    logic [1:0] w_new_state;
    logic [7:0] w_new_total;
    logic [7:0] w_new_change;
    logic [1:0] w_new_item;
    logic [1:0] w_live_state_nxt;
    logic       w_attract_now;
    logic       w_attract_nxt;

    // Pick the value applied at a frame boundary: a coincident strobe beats the shadow copy.
    always_comb begin
        w_apply_now      = bus.frame_start & (bus.upd_valid | r_pending);
        w_new_state      = bus.upd_valid ? bus.upd_state  : r_shadow_state;
        w_new_total      = bus.upd_valid ? bus.upd_total  : r_shadow_total;
        w_new_change     = bus.upd_valid ? bus.upd_change : r_shadow_change;
        w_new_item       = bus.upd_valid ? bus.upd_item   : r_shadow_item;
        w_live_state_nxt = w_apply_now ? w_new_state : r_live_state;
    end

    // Shadow capture between frames; copy to the display registers at frame_start.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_pending       <= 1'b0;
            r_shadow_state  <= 2'b00;
            r_shadow_total  <= 8'h00;
            r_shadow_change <= 8'h00;
            r_shadow_item   <= 2'b00;
            r_live_state    <= 2'b00;
            r_live_item     <= 2'b00;
            r_disp_total    <= 8'h00;
            r_disp_change   <= 8'h00;
        end else if (bus.frame_start) begin
            r_pending <= 1'b0;
            if (w_apply_now) begin
                r_live_state  <= w_new_state;
                r_live_item   <= w_new_item;
                r_disp_total  <= w_new_total;
                r_disp_change <= w_new_change;
            end
        end else if (bus.upd_valid) begin
            r_pending       <= 1'b1;
            r_shadow_state  <= bus.upd_state;
            r_shadow_total  <= bus.upd_total;
            r_shadow_change <= bus.upd_change;
            r_shadow_item   <= bus.upd_item;
        end
    end

    // Dispense request latch; a frame_start consumes it unless a new pulse arrives that cycle.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_dispense_pend <= 1'b0;
            r_banner_item   <= 2'b00;
        end else if (bus.dispense) begin
            r_dispense_pend <= 1'b1;
            r_banner_item   <= bus.upd_item;
        end else if (bus.frame_start) begin
            r_dispense_pend <= 1'b0;
        end
    end

    // Banner FSM state and hold counter register.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_LIVE;
            r_hold_cnt <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Banner FSM next state: enter or re-arm on a pending dispense, else count the hold down.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_load_banner = 1'b0;
        if (bus.frame_start) begin
            case (r_state)
                S_LIVE: begin
                    if (r_dispense_pend) begin
                        w_state_nxt   = S_BANNER;
                        w_hold_nxt    = 8'(HOLD_FRAMES - 1);
                        w_load_banner = 1'b1;
                    end
                end
                S_BANNER: begin
                    if (r_dispense_pend) begin
                        w_hold_nxt    = 8'(HOLD_FRAMES - 1);
                        w_load_banner = 1'b1;
                    end else if (r_hold_cnt == 8'h00) begin
                        w_state_nxt = S_LIVE;
                    end else begin
                        w_hold_nxt = r_hold_cnt - 8'h01;
                    end
                end
                default: w_state_nxt = S_LIVE;
            endcase
        end
    end

    // The banner item on screen only changes at a frame boundary, even if a dispense retriggers mid-frame.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_banner_shown <= 2'b00;
        end else if (w_load_banner) begin
            r_banner_shown <= r_banner_item;
        end
    end

    // Attract is LIVE with an idle state code, judged both now and after this boundary.
    always_comb begin
        w_attract_now = (r_state == S_LIVE) && (r_live_state == 2'b00);
        w_attract_nxt = (w_state_nxt == S_LIVE) && (w_live_state_nxt == 2'b00);
    end

    // Attract blink: advance while staying in attract, restart visible on entry, park otherwise.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt  <= 8'h00;
            r_blink_show <= 1'b1;
        end else if (bus.frame_start) begin
            if (w_attract_nxt && w_attract_now) begin
                if (r_blink_cnt >= 8'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt  <= 8'h00;
                    r_blink_show <= ~r_blink_show;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'h01;
                end
            end else begin
                r_blink_cnt  <= 8'h00;
                r_blink_show <= 1'b1;
            end
        end
    end

    assign bus.disp_state    = (r_state == S_BANNER) ? 2'b11 : r_live_state;
    assign bus.disp_item     = (r_state == S_BANNER) ? r_banner_shown : r_live_item;
    assign bus.disp_total    = r_disp_total;
    assign bus.disp_change   = r_disp_change;
    assign bus.show_text     = (r_state == S_BANNER) ? 1'b1 : r_blink_show;
    assign bus.banner_active = (r_state == S_BANNER);

endmodule
